// File: rtl/sdram_bridge_arbiter.sv
// Two-port arbiter onto one SDRAM pipeline bridge: port 0 wins unless port 1 has starved; one burst in flight.
// Request-to-command 1 cycle from IDLE; bridge waitrequest is passed to the owning port, the other port is held off.
module sdram_bridge_arbiter #(
  parameter int ADDR_W       = 26,
  parameter int DATA_W       = 16,
  parameter int BURST_W      = 10,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_read,
  input  logic [ADDR_W-1:0]  m0_address,
  input  logic [BURST_W-1:0] m0_burstcount,
  output logic               m0_waitrequest,
  output logic [DATA_W-1:0]  m0_readdata,
  output logic               m0_readdatavalid,
  input  logic               m1_read,
  input  logic               m1_write,
  input  logic [ADDR_W-1:0]  m1_address,
  input  logic [BURST_W-1:0] m1_burstcount,
  input  logic [DATA_W-1:0]  m1_writedata,
  output logic               m1_waitrequest,
  output logic [DATA_W-1:0]  m1_readdata,
  output logic               m1_readdatavalid,
  output logic               br_read,
  output logic               br_write,
  output logic [ADDR_W-1:0]  br_address,
  output logic [BURST_W-1:0] br_burstcount,
  output logic [DATA_W-1:0]  br_writedata,
  input  logic               br_waitrequest,
  input  logic [DATA_W-1:0]  br_readdata,
  input  logic               br_readdatavalid,
  output logic [1:0]         grant,
  output logic               protocol_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CMD, RD_DATA, WR_DATA} state_t;

  state_t             state;
  logic               is_wr;
  logic [BURST_W-1:0] burst;
  logic [BURST_W-1:0] beats;
  logic [SW-1:0]      starve;

  logic               m0_pend, m1_pend, pick_m1, bus_on;
  logic [BURST_W-1:0] req_burst;
  logic [BURST_W-1:0] beats_nxt;

  assign m0_pend   = m0_read;
  assign m1_pend   = m1_read | m1_write;
  assign pick_m1   = m1_pend && (!m0_pend || starve >= STARVE_MAX);
  assign req_burst = pick_m1 ? m1_burstcount : m0_burstcount;
  assign beats_nxt = beats + BURST_W'(1);

  assign br_read       = (state == CMD) && !is_wr;
  assign br_write      = ((state == CMD) || (state == WR_DATA)) && is_wr;
  assign bus_on        = br_read | br_write;
  assign br_address    = bus_on ? (grant[1] ? m1_address : m0_address) : '0;
  assign br_burstcount = bus_on ? burst : '0;
  assign br_writedata  = br_write ? m1_writedata : '0;

  assign m0_waitrequest   = !(bus_on && grant[0]) || br_waitrequest;
  assign m1_waitrequest   = !(bus_on && grant[1]) || br_waitrequest;
  assign m0_readdata      = br_readdata;
  assign m1_readdata      = br_readdata;
  assign m0_readdatavalid = (state == RD_DATA) && grant[0] && br_readdatavalid;
  assign m1_readdatavalid = (state == RD_DATA) && grant[1] && br_readdatavalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= 2'b00;
      is_wr        <= 1'b0;
      burst        <= '0;
      beats        <= '0;
      starve       <= '0;
      protocol_err <= 1'b0;
    end else begin
      // Port 1 only ages while someone else holds the bus or wins arbitration.
      if ((state == IDLE) && pick_m1)
        starve <= '0;
      else if (m1_pend && !grant[1] && (starve != STARVE_MAX))
        starve <= starve + SW'(1);

      if (br_readdatavalid && (state != RD_DATA))
        protocol_err <= 1'b1;

      case (state)
        IDLE: begin
          if (m0_pend || m1_pend) begin
            grant <= pick_m1 ? 2'b10 : 2'b01;
            is_wr <= pick_m1 && m1_write;
            burst <= (req_burst == '0) ? BURST_W'(1) : req_burst;
            beats <= '0;
            if (pick_m1 && m1_read && m1_write)
              protocol_err <= 1'b1;
            state <= CMD;
          end
        end
        CMD: begin
          if (!br_waitrequest) begin
            if (!is_wr) begin
              state <= RD_DATA;
            end else if (burst == BURST_W'(1)) begin
              state <= IDLE;
              grant <= 2'b00;
            end else begin
              state <= WR_DATA;
              beats <= BURST_W'(1);
            end
          end
        end
        WR_DATA: begin
          if (!br_waitrequest) begin
            beats <= beats_nxt;
            if (beats_nxt == burst) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        RD_DATA: begin
          if (br_readdatavalid) begin
            beats <= beats_nxt;
            if (beats_nxt == burst) begin
              state <= IDLE;
              grant <= 2'b00;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_bridge_arbiter.sv
// Directed bench for sdram_bridge_arbiter with a small latency-programmable bridge responder.
module tb_sdram_bridge_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_read = 1'b0;
  logic [25:0] m0_address = '0;
  logic [9:0]  m0_burstcount = '0;
  logic        m0_waitrequest;
  logic [15:0] m0_readdata;
  logic        m0_readdatavalid;
  logic        m1_read = 1'b0;
  logic        m1_write = 1'b0;
  logic [25:0] m1_address = '0;
  logic [9:0]  m1_burstcount = '0;
  logic [15:0] m1_writedata = '0;
  logic        m1_waitrequest;
  logic [15:0] m1_readdata;
  logic        m1_readdatavalid;
  logic        br_read, br_write;
  logic [25:0] br_address;
  logic [9:0]  br_burstcount;
  logic [15:0] br_writedata;
  logic        br_waitrequest = 1'b0;
  logic [15:0] br_readdata = '0;
  logic        model_vld = 1'b0;
  logic        force_stray = 1'b0;
  wire         br_readdatavalid = model_vld | force_stray;
  logic [1:0]  grant;
  logic        protocol_err;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_bridge_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_read(m0_read), .m0_address(m0_address), .m0_burstcount(m0_burstcount),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address), .m1_burstcount(m1_burstcount),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .br_read(br_read), .br_write(br_write), .br_address(br_address), .br_burstcount(br_burstcount),
    .br_writedata(br_writedata), .br_waitrequest(br_waitrequest), .br_readdata(br_readdata),
    .br_readdatavalid(br_readdatavalid),
    .grant(grant), .protocol_err(protocol_err)
  );

  // Bridge responder: a read accepted at an edge returns beats A000+i starting lat cycles later.
  int lat = 1;
  int cyc = 0;
  int pend = 0;
  int start = 0;
  int idx = 0;
  always begin
    logic acc;
    logic [9:0] bc;
    @(negedge clk);
    acc = br_read && !br_waitrequest;
    bc  = br_burstcount;
    @(posedge clk);
    cyc++;
    #1;
    if (acc) begin
      pend  = (bc == 10'd0) ? 512 : int'(bc);
      start = cyc - 1 + lat;
      idx   = 0;
    end
    if (pend > 0 && cyc >= start) begin
      model_vld   = 1'b1;
      br_readdata = 16'hA000 + 16'(idx);
      idx++;
      pend--;
    end else begin
      model_vld = 1'b0;
    end
  end

  // Observation counters, sampled mid-cycle.
  int          cnt_m0 = 0, cnt_m1 = 0, cnt_brrd = 0, cnt_m0_acc = 0, cnt_m1_acc = 0;
  int          bcast_bad = 0, wcnt = 0;
  logic [15:0] last_m0 = '0;
  logic [15:0] wr_log [8];
  always @(negedge clk) begin
    if (m0_readdatavalid) begin
      cnt_m0++;
      last_m0 = m0_readdata;
    end
    if (m1_readdatavalid) cnt_m1++;
    if (br_read) cnt_brrd++;
    if (br_read && !br_waitrequest && grant == 2'b01) cnt_m0_acc++;
    if (br_read && !br_waitrequest && grant == 2'b10) cnt_m1_acc++;
    if (m0_readdata !== br_readdata || m1_readdata !== br_readdata) bcast_bad++;
    if (br_write && !br_waitrequest) begin
      if (wcnt < 8) wr_log[wcnt] = br_writedata;
      wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && grant != 2'b00; i++) step();
  endtask

  initial begin
    int b0, b1, bb, base_m0;

    // Reset state
    step(); step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_err", 32'(protocol_err), 32'h0);
    chk("rst_br_read", 32'(br_read), 32'h0);
    chk("rst_br_write", 32'(br_write), 32'h0);
    chk("rst_br_addr", 32'(br_address), 32'h0);
    chk("rst_br_bc", 32'(br_burstcount), 32'h0);
    chk("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
    chk("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
    chk("rst_m0_vld", 32'(m0_readdatavalid), 32'h0);
    rst_n = 1'b1;
    step();

    // m0 read 512 beats, bridge latency 3
    lat = 3;
    b0 = cnt_m0; b1 = cnt_m1; bb = cnt_brrd;
    m0_read = 1'b1; m0_address = 26'h1E0_0000; m0_burstcount = 10'd512;
    step();
    chk("t1_br_read", 32'(br_read), 32'h1);
    chk("t1_br_addr", 32'(br_address), 32'h1E0_0000);
    chk("t1_br_bc", 32'(br_burstcount), 32'd512);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_m0_wait", 32'(m0_waitrequest), 32'h0);
    chk("t1_m1_wait", 32'(m1_waitrequest), 32'h1);
    step();
    m0_read = 1'b0;
    chk("t1_br_read_off", 32'(br_read), 32'h0);
    wait_idle(2000);
    chk("t1_grant_idle", 32'(grant), 32'h0);
    chk("t1_m0_beats", 32'(cnt_m0 - b0), 32'd512);
    chk("t1_m1_beats", 32'(cnt_m1 - b1), 32'd0);
    chk("t1_br_read_cycles", 32'(cnt_brrd - bb), 32'd1);
    chk("t1_last_data", 32'(last_m0), 32'hA1FF);
    chk("t1_broadcast", 32'(bcast_bad), 32'd0);

    // m1 write burst 4, stall on beat 2
    m1_write = 1'b1; m1_address = 26'h100; m1_burstcount = 10'd4; m1_writedata = 16'h1111;
    step();
    chk("t2_br_write", 32'(br_write), 32'h1);
    chk("t2_wdata1", 32'(br_writedata), 32'h1111);
    chk("t2_grant", 32'(grant), 32'h2);
    chk("t2_m1_wait", 32'(m1_waitrequest), 32'h0);
    chk("t2_m0_wait", 32'(m0_waitrequest), 32'h1);
    step();
    m1_writedata = 16'h2222; br_waitrequest = 1'b1;
    #1;
    chk("t2_m1_wait_stall", 32'(m1_waitrequest), 32'h1);
    step();
    chk("t2_wdata_held", 32'(br_writedata), 32'h2222);
    chk("t2_write_held", 32'(br_write), 32'h1);
    br_waitrequest = 1'b0;
    #1;
    chk("t2_m1_wait_release", 32'(m1_waitrequest), 32'h0);
    step();
    m1_writedata = 16'h3333;
    step();
    m1_writedata = 16'h4444;
    step();
    m1_write = 1'b0;
    chk("t2_grant_idle", 32'(grant), 32'h0);
    chk("t2_wcnt", 32'(wcnt), 32'd4);
    chk("t2_w0", 32'(wr_log[0]), 32'h1111);
    chk("t2_w1", 32'(wr_log[1]), 32'h2222);
    chk("t2_w2", 32'(wr_log[2]), 32'h3333);
    chk("t2_w3", 32'(wr_log[3]), 32'h4444);

    // Starvation guard: m0 re-requests single-beat reads, m1 waits
    rst_n = 1'b0; step(); rst_n = 1'b1;
    lat = 1;
    b0 = cnt_m0_acc; b1 = cnt_m1_acc;
    m0_read = 1'b1; m0_address = 26'h40; m0_burstcount = 10'd1;
    m1_read = 1'b1; m1_address = 26'h80; m1_burstcount = 10'd1;
    for (int i = 0; i < 300 && cnt_m1_acc == b1; i++) step();
    m0_read = 1'b0; m1_read = 1'b0;
    chk("t3_m1_granted", 32'(cnt_m1_acc - b1), 32'd1);
    chk("t3_m0_wins", 32'(cnt_m0_acc - b0), 32'd22);
    wait_idle(50);
    chk("t3_idle", 32'(grant), 32'h0);

    // m1 read with burstcount 0 behaves as one beat
    b0 = cnt_m0; b1 = cnt_m1;
    m1_read = 1'b1; m1_address = 26'h2000; m1_burstcount = 10'd0;
    step();
    chk("t4_br_read", 32'(br_read), 32'h1);
    chk("t4_br_bc", 32'(br_burstcount), 32'd1);
    chk("t4_grant", 32'(grant), 32'h2);
    step();
    m1_read = 1'b0;
    wait_idle(50);
    chk("t4_idle", 32'(grant), 32'h0);
    chk("t4_m1_beats", 32'(cnt_m1 - b1), 32'd1);
    chk("t4_m0_beats", 32'(cnt_m0 - b0), 32'd0);

    // Stray beat while idle
    step();
    chk("t5_err_before", 32'(protocol_err), 32'h0);
    force_stray = 1'b1;
    #1;
    chk("t5_m0_vld", 32'(m0_readdatavalid), 32'h0);
    chk("t5_m1_vld", 32'(m1_readdatavalid), 32'h0);
    step();
    force_stray = 1'b0;
    chk("t5_err_set", 32'(protocol_err), 32'h1);
    step(); step(); step();
    chk("t5_err_sticky", 32'(protocol_err), 32'h1);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("t5_err_cleared", 32'(protocol_err), 32'h0);

    // Reset during a 512-beat read after beat 100
    m0_read = 1'b1; m0_address = 26'h0; m0_burstcount = 10'd512;
    base_m0 = cnt_m0;
    step();
    step();
    m0_read = 1'b0;
    for (int i = 0; i < 1000 && (cnt_m0 - base_m0) < 100; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_br_read", 32'(br_read), 32'h0);
    chk("t6_m0_vld", 32'(m0_readdatavalid), 32'h0);
    chk("t6_m0_wait", 32'(m0_waitrequest), 32'h1);
    step();
    chk("t6_err", 32'(protocol_err), 32'h1);
    for (int i = 0; i < 1000 && pend > 0; i++) step();
    step();
    chk("t6_m0_beats", 32'(cnt_m0 - base_m0), 32'd101);
    chk("t6_grant_end", 32'(grant), 32'h0);
    chk("t6_err_end", 32'(protocol_err), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
